// File: rtl/rgb_pkg.sv
// rtl/rgb_pkg.sv - shared types and word-format constants for the RGB frame scheduler
package rgb_pkg;

  localparam int WORD_W       = 32;
  localparam int PIXEL_W      = 24;
  localparam int WORD_EOF_BIT = 24;

  // Scheduler states; IDLE must stay the all-zero encoding so reset lands there
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_DEC   = 3'd2,
    ST_SEND  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_LATCH = 3'd5
  } state_t;

endpackage

// File: rtl/rgb_frame_sched_if.sv
// rtl/rgb_frame_sched_if.sv - FIFO read side and serializer handshake bundle
interface rgb_frame_sched_if;
  import rgb_pkg::*;

  logic               fifo_empty;
  logic [WORD_W-1:0]  fifo_word;
  logic               fifo_rd;
  logic               ser_valid;
  logic               ser_ready;
  logic               ser_idle;
  logic [PIXEL_W-1:0] ser_pixel;

  // master: the scheduler; slave: FIFO + serializer side
  modport master (
    input  fifo_empty, fifo_word, ser_ready, ser_idle,
    output fifo_rd, ser_valid, ser_pixel
  );

  modport slave (
    output fifo_empty, fifo_word, ser_ready, ser_idle,
    input  fifo_rd, ser_valid, ser_pixel
  );

endinterface

// File: rtl/rgb_latch_timer.sv
// rtl/rgb_latch_timer.sv - load/count-down timer with done pulse for the output latch period
module rgb_latch_timer #(
  parameter int LATCH_CLKS = 4800
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);

  localparam int            CW       = (LATCH_CLKS > 1) ? $clog2(LATCH_CLKS) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(LATCH_CLKS - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          active_q, active_d;

  // done is high on the final counted cycle, so a load-to-done span is LATCH_CLKS cycles
  assign done = active_q && (cnt_q == '0);

  // next count: load wins, otherwise count down while active and stop after zero
  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    if (load) begin
      cnt_d    = LOAD_VAL;
      active_d = 1'b1;
    end else if (active_q) begin
      if (cnt_q == '0) begin
        active_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/rgb_frame_sched.sv
// rtl/rgb_frame_sched.sv - pops pixel words, feeds the serializer and times the frame latch
module rgb_frame_sched
  import rgb_pkg::*;
#(
  parameter int NUM_LEDS   = 60,
  parameter int LATCH_CLKS = 4800,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  rgb_frame_sched_if.master bus,
  output logic             latch_active,
  output logic [CNT_W-1:0] led_count,
  output logic [CNT_W-1:0] frame_count,
  output logic             overrun
);

  state_t                state_q, state_d;
  logic                  fifo_rd_q, fifo_rd_d;
  logic                  ser_valid_q, ser_valid_d;
  logic [PIXEL_W-1:0]    ser_pixel_q, ser_pixel_d;
  logic [WORD_EOF_BIT:0] hold_q, hold_d;
  logic                  latch_active_q, latch_active_d;
  logic [CNT_W-1:0]      led_count_q, led_count_d;
  logic [CNT_W-1:0]      frame_count_q, frame_count_d;
  logic                  overrun_q, overrun_d;
  logic                  tmr_load;
  logic                  tmr_done;
  logic [WORD_W-1:WORD_EOF_BIT+1] unused_word_hi;

  // upper word bits carry no meaning and are deliberately dropped
  assign unused_word_hi = bus.fifo_word[WORD_W-1:WORD_EOF_BIT+1];

  rgb_latch_timer #(
    .LATCH_CLKS (LATCH_CLKS)
  ) u_latch_timer (
    .clk  (clk),
    .rst  (rst),
    .load (tmr_load),
    .done (tmr_done)
  );

  // next-state and registered-output logic; fifo_rd is raised from IDLE and the
  // move to WAIT happens on the edge that pops, so the word is valid during WAIT
  always_comb begin
    state_d        = state_q;
    fifo_rd_d      = 1'b0;
    ser_valid_d    = ser_valid_q;
    ser_pixel_d    = ser_pixel_q;
    hold_d         = hold_q;
    latch_active_d = latch_active_q;
    led_count_d    = led_count_q;
    frame_count_d  = frame_count_q;
    overrun_d      = overrun_q;
    tmr_load       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fifo_rd_q) begin
          state_d = ST_WAIT;
        end else if (!bus.fifo_empty) begin
          fifo_rd_d = 1'b1;
        end
      end

      ST_WAIT: begin
        hold_d  = bus.fifo_word[WORD_EOF_BIT:0];
        state_d = ST_DEC;
      end

      ST_DEC: begin
        if (hold_q[WORD_EOF_BIT]) begin
          // an EOF with nothing sent is a stray stream reset: no latch, no frame
          state_d = (led_count_q == '0) ? ST_IDLE : ST_DRAIN;
        end else if (led_count_q == CNT_W'(NUM_LEDS)) begin
          overrun_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          ser_valid_d = 1'b1;
          ser_pixel_d = hold_q[PIXEL_W-1:0];
          state_d     = ST_SEND;
        end
      end

      ST_SEND: begin
        if (bus.ser_ready) begin
          ser_valid_d = 1'b0;
          led_count_d = led_count_q + CNT_W'(1);
          state_d     = ST_IDLE;
        end
      end

      ST_DRAIN: begin
        if (bus.ser_idle) begin
          tmr_load       = 1'b1;
          latch_active_d = 1'b1;
          state_d        = ST_LATCH;
        end
      end

      ST_LATCH: begin
        if (tmr_done) begin
          latch_active_d = 1'b0;
          frame_count_d  = frame_count_q + CNT_W'(1);
          led_count_d    = '0;
          state_d        = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      fifo_rd_q      <= 1'b0;
      ser_valid_q    <= 1'b0;
      ser_pixel_q    <= '0;
      hold_q         <= '0;
      latch_active_q <= 1'b0;
      led_count_q    <= '0;
      frame_count_q  <= '0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      fifo_rd_q      <= fifo_rd_d;
      ser_valid_q    <= ser_valid_d;
      ser_pixel_q    <= ser_pixel_d;
      hold_q         <= hold_d;
      latch_active_q <= latch_active_d;
      led_count_q    <= led_count_d;
      frame_count_q  <= frame_count_d;
      overrun_q      <= overrun_d;
    end
  end

  assign bus.fifo_rd   = fifo_rd_q;
  assign bus.ser_valid = ser_valid_q;
  assign bus.ser_pixel = ser_pixel_q;
  assign latch_active  = latch_active_q;
  assign led_count     = led_count_q;
  assign frame_count   = frame_count_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_rgb_frame_sched.sv
// tb/tb_rgb_frame_sched.sv - directed scoreboard bench for rgb_frame_sched
module tb_rgb_frame_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        latch_active;
  logic [15:0] led_count;
  logic [15:0] frame_count;
  logic        overrun;

  rgb_frame_sched_if bus ();

  rgb_frame_sched #(
    .NUM_LEDS   (4),
    .LATCH_CLKS (4800),
    .CNT_W      (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .latch_active (latch_active),
    .led_count    (led_count),
    .frame_count  (frame_count),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  logic [31:0] fifo_q[$];
  logic [23:0] exp_q[$];
  int n_checks    = 0;
  int n_errors    = 0;
  int rd_cnt      = 0;
  int acc_cnt     = 0;
  int latch_rises = 0;
  logic prev_valid = 1'b0;
  logic prev_ready = 1'b0;
  logic prev_latch = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // word FIFO model: registered read data, valid the cycle after fifo_rd
  always @(posedge clk) begin
    if (bus.fifo_rd && fifo_q.size() != 0) bus.fifo_word <= fifo_q.pop_front();
    bus.fifo_empty <= (fifo_q.size() == 0);
  end

  // output monitor: scoreboard compare, handshake rules, pop and latch counting
  always @(negedge clk) begin
    if (!rst) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (prev_valid && !prev_ready) chk("valid_hold", bus.ser_valid, 1'b1);
      if (bus.ser_valid) begin
        chk("valid_with_expect", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          chk("pixel", bus.ser_pixel, exp_q[0]);
          if (bus.ser_ready) begin
            void'(exp_q.pop_front());
            acc_cnt++;
          end
        end
      end
      if (bus.fifo_rd) rd_cnt++;
      prev_valid = bus.ser_valid;
      prev_ready = bus.ser_ready;
    end
    if (latch_active && !prev_latch) latch_rises++;
    prev_latch = latch_active;
  end

  task automatic wait_frame(input string tag);
    int k   = 0;
    int len = 0;
    while (!latch_active && k < 300) begin
      step();
      k++;
    end
    chk({tag, "_latch_start"}, latch_active, 1'b1);
    while (latch_active && len < 6000) begin
      len++;
      step();
    end
    chk({tag, "_latch_len"}, len, 4800);
  endtask

  initial begin
    int k;
    int r0;
    bus.ser_ready = 1'b0;
    bus.ser_idle  = 1'b1;
    repeat (3) step();
    chk("rst_valid", bus.ser_valid, 1'b0);
    chk("rst_rd", bus.fifo_rd, 1'b0);
    chk("rst_latch", latch_active, 1'b0);
    chk("rst_frames", frame_count, 16'd0);
    rst = 1'b1;
    repeat (2) step();

    // 1: reset while a pixel waits for ser_ready
    fifo_q.push_back(32'h00ABCDEF);
    exp_q.push_back(24'hABCDEF);
    k = 0;
    while (!bus.ser_valid && k < 20) begin step(); k++; end
    chk("t1_valid_seen", bus.ser_valid, 1'b1);
    chk("t1_pixel", bus.ser_pixel, 24'hABCDEF);
    rst = 1'b0;
    #1;
    chk("t1_rst_valid", bus.ser_valid, 1'b0);
    chk("t1_rst_pixel", bus.ser_pixel, 24'h0);
    chk("t1_rst_rd", bus.fifo_rd, 1'b0);
    chk("t1_rst_led", led_count, 16'd0);
    chk("t1_rst_ovr", overrun, 1'b0);
    exp_q.delete();
    repeat (3) step();
    rst = 1'b1;
    rd_cnt = 0;
    repeat (10) step();
    chk("t1_no_pop", rd_cnt, 0);
    chk("t1_idle_valid", bus.ser_valid, 1'b0);

    // 2: three pixels + EOF, latch held off until the serializer is idle
    bus.ser_idle  = 1'b0;
    bus.ser_ready = 1'b1;
    acc_cnt = 0;
    fifo_q.push_back(32'h00FF0000); exp_q.push_back(24'hFF0000);
    fifo_q.push_back(32'h0000FF00); exp_q.push_back(24'h00FF00);
    fifo_q.push_back(32'h000000FF); exp_q.push_back(24'h0000FF);
    fifo_q.push_back(32'h01000000);
    repeat (40) step();
    chk("t2_led", led_count, 16'd3);
    chk("t2_acc", acc_cnt, 3);
    chk("t2_drain_nolatch", latch_active, 1'b0);
    bus.ser_idle = 1'b1;
    wait_frame("t2");
    chk("t2_frames", frame_count, 16'd1);
    chk("t2_led_clr", led_count, 16'd0);

    // 3: same stream with ser_ready withheld for 20 cycles
    bus.ser_ready = 1'b0;
    rd_cnt = 0;
    acc_cnt = 0;
    fifo_q.push_back(32'h00FF0000); exp_q.push_back(24'hFF0000);
    fifo_q.push_back(32'h0000FF00); exp_q.push_back(24'h00FF00);
    fifo_q.push_back(32'h000000FF); exp_q.push_back(24'h0000FF);
    fifo_q.push_back(32'h01000000);
    k = 0;
    while (!bus.ser_valid && k < 20) begin step(); k++; end
    repeat (20) step();
    chk("t3_valid", bus.ser_valid, 1'b1);
    chk("t3_pixel", bus.ser_pixel, 24'hFF0000);
    chk("t3_one_pop", rd_cnt, 1);
    bus.ser_ready = 1'b1;
    wait_frame("t3");
    chk("t3_frames", frame_count, 16'd2);
    chk("t3_acc", acc_cnt, 3);
    chk("t3_ovr", overrun, 1'b0);

    // 4: six pixels against a 4-LED limit, upper word bits set
    bus.ser_idle = 1'b0;
    rd_cnt = 0;
    acc_cnt = 0;
    fifo_q.push_back(32'h00100001); exp_q.push_back(24'h100001);
    fifo_q.push_back(32'hFE123456); exp_q.push_back(24'h123456);
    fifo_q.push_back(32'h00100003); exp_q.push_back(24'h100003);
    fifo_q.push_back(32'h00100004); exp_q.push_back(24'h100004);
    fifo_q.push_back(32'h00100005);
    fifo_q.push_back(32'h00100006);
    fifo_q.push_back(32'h81000000);
    repeat (60) step();
    chk("t4_led", led_count, 16'd4);
    chk("t4_ovr", overrun, 1'b1);
    chk("t4_acc", acc_cnt, 4);
    chk("t4_pops", rd_cnt, 7);
    chk("t4_drain_nolatch", latch_active, 1'b0);
    bus.ser_idle = 1'b1;
    wait_frame("t4");
    chk("t4_led_clr", led_count, 16'd0);
    chk("t4_frames", frame_count, 16'd3);
    chk("t4_ovr_sticky", overrun, 1'b1);

    // 5: EOF on an empty frame is discarded
    rd_cnt = 0;
    r0 = latch_rises;
    fifo_q.push_back(32'h01000000);
    repeat (20) step();
    chk("t5_pop", rd_cnt, 1);
    chk("t5_no_latch", latch_rises - r0, 0);
    chk("t5_frames", frame_count, 16'd3);

    // 6: one pixel then two EOFs -> one frame
    rd_cnt = 0;
    acc_cnt = 0;
    r0 = latch_rises;
    fifo_q.push_back(32'h00C0FFEE); exp_q.push_back(24'hC0FFEE);
    fifo_q.push_back(32'h01000000);
    fifo_q.push_back(32'h01000000);
    wait_frame("t6");
    repeat (20) step();
    chk("t6_frames", frame_count, 16'd4);
    chk("t6_pops", rd_cnt, 3);
    chk("t6_one_latch", latch_rises - r0, 1);
    chk("t6_led", led_count, 16'd0);
    chk("t6_acc", acc_cnt, 1);

    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
